// File: rtl/lzx_gate_pkg.sv
// Mode encoding shared by the 74-series style blocks of the gate library.
// The mode constants are used by both the RTL and the benches.
package lzx_gate_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/lzx_shift_store_reg_if.sv
// Control/data bundle of the universal shift/storage register.
// The master drives mode, serial, parallel and strobe inputs; the slave returns Q and the cascade/full flags.
interface lzx_shift_store_reg_if #(parameter int WIDTH = 8);

    logic [1:0]       S;
    logic             DSR;
    logic             DSL;
    logic [WIDTH-1:0] P;
    logic             ST;
    logic             OE_N;
    logic [WIDTH-1:0] Q;
    logic             QSR;
    logic             QSL;
    logic             FULL;

    modport master (
        output S, DSR, DSL, P, ST, OE_N,
        input  Q, QSR, QSL, FULL
    );

    modport slave (
        input  S, DSR, DSL, P, ST, OE_N,
        output Q, QSR, QSL, FULL
    );

endinterface

// File: rtl/lzx_univ_shift_core.sv
// 74HC194-style shift stage: hold, shift right, shift left, parallel load.
// Cascade outputs are taken straight from the end bits of the stage.
module lzx_univ_shift_core
    import lzx_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] sr,
    output logic             qsr,
    output logic             qsl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            case (mode)
                MODE_SHR:  sr <= {dsr, sr[WIDTH-1:1]};
                MODE_SHL:  sr <= {sr[WIDTH-2:0], dsl};
                MODE_LOAD: sr <= p;
                default:   sr <= sr;
            endcase
        end
    end

    assign qsr = sr[0];
    assign qsl = sr[WIDTH-1];

endmodule

// File: rtl/lzx_shift_store_reg.sv
// Universal shift register with a pipelined storage stage, shift counter and gated outputs.
// The storage stage captures the shift stage as it was before the strobing edge.
module lzx_shift_store_reg
    import lzx_gate_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RD,
    lzx_shift_store_reg_if.slave bus
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] st_r;
    logic [CNT_W-1:0] cnt;
    logic             qsr;
    logic             qsl;

    lzx_univ_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk   (CLK),
        .rst_n (RD),
        .mode  (bus.S),
        .dsr   (bus.DSR),
        .dsl   (bus.DSL),
        .p     (bus.P),
        .sr    (sr),
        .qsr   (qsr),
        .qsl   (qsl)
    );

    // A strobe restarts word assembly, so it outranks a coincident shift.
    always_ff @(posedge CLK or negedge RD) begin
        if (!RD) begin
            st_r <= '0;
            cnt  <= '0;
        end else begin
            if (bus.ST) begin
                st_r <= sr;
            end
            if (bus.ST) begin
                cnt <= '0;
            end else begin
                case (bus.S)
                    MODE_LOAD: cnt <= '0;
                    MODE_SHR, MODE_SHL: begin
                        if (cnt != CNT_W'(WIDTH)) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign bus.Q    = bus.OE_N ? '0 : st_r;
    assign bus.QSR  = qsr;
    assign bus.QSL  = qsl;
    assign bus.FULL = (cnt == CNT_W'(WIDTH));

endmodule

// File: tb/tb_lzx_shift_store_reg.sv
// Directed bench for lzx_shift_store_reg with an 8-bit and a 4-bit instance.
module tb_lzx_shift_store_reg;
    import lzx_gate_pkg::*;

    logic CLK;
    logic RD;
    int   checks;
    int   errors;

    lzx_shift_store_reg_if #(.WIDTH(8)) bus8 ();
    lzx_shift_store_reg_if #(.WIDTH(4)) bus4 ();

    lzx_shift_store_reg #(.WIDTH(8)) dut8 (.CLK(CLK), .RD(RD), .bus(bus8.slave));
    lzx_shift_store_reg #(.WIDTH(4)) dut4 (.CLK(CLK), .RD(RD), .bus(bus4.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RD = 1'b0;
        #2;
        checks++;
        if (bus8.Q !== 8'h00 || bus8.FULL !== 1'b0 || bus8.QSR !== 1'b0 || bus8.QSL !== 1'b0) begin
            errors++;
            $display("FAIL reset_init Q=%h FULL=%b QSR=%b QSL=%b required all 0", bus8.Q, bus8.FULL, bus8.QSR, bus8.QSL);
        end
        tick();
        RD = 1'b1;
        bus8.S = MODE_LOAD; bus8.P = 8'hA5;
        tick();
        bus8.S = MODE_HOLD; bus8.ST = 1'b1;
        tick();
        checks++;
        if (bus8.Q !== 8'hA5 || bus8.QSR !== 1'b1 || bus8.QSL !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload Q=%h QSR=%b QSL=%b required a5 1 1", bus8.Q, bus8.QSR, bus8.QSL);
        end
        bus8.ST = 1'b0; bus8.S = MODE_SHR; bus8.DSR = 1'b1;
        tick();
        #2;
        RD = 1'b0;
        #1;
        checks++;
        if (bus8.Q !== 8'h00 || bus8.FULL !== 1'b0 || bus8.QSR !== 1'b0 || bus8.QSL !== 1'b0 || dut8.sr !== 8'h00) begin
            errors++;
            $display("FAIL reset_async Q=%h FULL=%b QSR=%b QSL=%b SR=%h required all 0", bus8.Q, bus8.FULL, bus8.QSR, bus8.QSL, dut8.sr);
        end
        bus8.S = MODE_LOAD; bus8.P = 8'hFF; bus8.ST = 1'b1;
        tick();
        tick();
        checks++;
        if (bus8.Q !== 8'h00 || dut8.sr !== 8'h00 || dut8.cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold_edges Q=%h SR=%h CNT=%0d required 00 00 0", bus8.Q, dut8.sr, dut8.cnt);
        end
        bus8.S = MODE_HOLD; bus8.ST = 1'b0; bus8.P = 8'h00; bus8.DSR = 1'b0;
        RD = 1'b1;
        tick();
    endtask

    task automatic test_parallel();
        bus8.S = MODE_LOAD; bus8.P = 8'h3C;
        tick();
        checks++;
        if (bus8.Q !== 8'h00 || dut8.sr !== 8'h3C || bus8.QSR !== 1'b0 || bus8.QSL !== 1'b0) begin
            errors++;
            $display("FAIL parallel_load Q=%h SR=%h required 00 3c", bus8.Q, dut8.sr);
        end
        bus8.S = MODE_HOLD; bus8.P = 8'hFF; bus8.ST = 1'b1;
        tick();
        checks++;
        if (bus8.Q !== 8'h3C || dut8.sr !== 8'h3C) begin
            errors++;
            $display("FAIL parallel_store Q=%h SR=%h required 3c 3c", bus8.Q, dut8.sr);
        end
        bus8.ST = 1'b0; bus8.OE_N = 1'b1;
        #1;
        checks++;
        if (bus8.Q !== 8'h00) begin
            errors++;
            $display("FAIL oe_disable Q=%h required 00", bus8.Q);
        end
        bus8.OE_N = 1'b0;
        #1;
        checks++;
        if (bus8.Q !== 8'h3C) begin
            errors++;
            $display("FAIL oe_reenable Q=%h required 3c", bus8.Q);
        end
    endtask

    task automatic test_serial_right();
        logic [7:0] seq;
        seq = 8'b1011_0010;
        bus8.S = MODE_LOAD; bus8.P = 8'h00; bus8.ST = 1'b1;
        tick();
        bus8.ST = 1'b0; bus8.S = MODE_SHR;
        for (int i = 0; i < 8; i++) begin
            bus8.DSR = seq[7-i];
            tick();
            if (i == 6) begin
                checks++;
                if (bus8.FULL !== 1'b0) begin
                    errors++;
                    $display("FAIL serial_full_early FULL=%b required 0 after 7 shifts", bus8.FULL);
                end
            end
        end
        checks++;
        if (bus8.FULL !== 1'b1 || dut8.sr !== 8'h4D) begin
            errors++;
            $display("FAIL serial_full FULL=%b SR=%h required 1 4d", bus8.FULL, dut8.sr);
        end
        bus8.S = MODE_HOLD; bus8.ST = 1'b1;
        tick();
        bus8.ST = 1'b0;
        checks++;
        if (bus8.Q !== 8'h4D || bus8.FULL !== 1'b0) begin
            errors++;
            $display("FAIL serial_store Q=%h FULL=%b required 4d 0", bus8.Q, bus8.FULL);
        end
    endtask

    task automatic test_shift_left();
        bus8.S = MODE_LOAD; bus8.P = 8'h81;
        tick();
        checks++;
        if (bus8.QSL !== 1'b1 || bus8.QSR !== 1'b1) begin
            errors++;
            $display("FAIL shl_before QSL=%b QSR=%b required 1 1", bus8.QSL, bus8.QSR);
        end
        bus8.S = MODE_SHL; bus8.DSL = 1'b0;
        tick();
        bus8.S = MODE_HOLD;
        checks++;
        if (dut8.sr !== 8'h02 || bus8.QSL !== 1'b0 || bus8.QSR !== 1'b0 || dut8.cnt !== 4'd1) begin
            errors++;
            $display("FAIL shl_after SR=%h QSL=%b QSR=%b CNT=%0d required 02 0 0 1", dut8.sr, bus8.QSL, bus8.QSR, dut8.cnt);
        end
    endtask

    task automatic test_st_with_shift();
        bus8.S = MODE_LOAD; bus8.P = 8'hF0;
        tick();
        bus8.S = MODE_SHR; bus8.DSR = 1'b1; bus8.ST = 1'b1;
        tick();
        bus8.S = MODE_HOLD; bus8.ST = 1'b0;
        checks++;
        if (bus8.Q !== 8'hF0 || dut8.sr !== 8'hF8 || dut8.cnt !== 4'd0) begin
            errors++;
            $display("FAIL st_shift Q=%h SR=%h CNT=%0d required f0 f8 0", bus8.Q, dut8.sr, dut8.cnt);
        end
    endtask

    task automatic test_last_bit_store();
        bus8.S = MODE_LOAD; bus8.P = 8'h00;
        tick();
        bus8.S = MODE_SHR; bus8.DSR = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus8.ST = 1'b1;
        tick();
        bus8.S = MODE_HOLD; bus8.ST = 1'b0;
        checks++;
        if (bus8.Q !== 8'hFE || dut8.sr !== 8'hFF || bus8.FULL !== 1'b0) begin
            errors++;
            $display("FAIL last_bit_store Q=%h SR=%h FULL=%b required fe ff 0", bus8.Q, dut8.sr, bus8.FULL);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] seq;
        seq = 6'b110010;
        bus4.S = MODE_LOAD; bus4.P = 4'h0;
        tick();
        bus4.S = MODE_SHR;
        for (int i = 0; i < 6; i++) begin
            bus4.DSR = seq[5-i];
            tick();
            if (i == 3) begin
                checks++;
                if (bus4.FULL !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_full4 FULL=%b required 1 after 4 shifts", bus4.FULL);
                end
            end
        end
        checks++;
        if (bus4.FULL !== 1'b1 || dut4.cnt !== 3'd4 || dut4.sr !== 4'h4 || bus4.QSR !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold FULL=%b CNT=%0d SR=%h QSR=%b required 1 4 4 0", bus4.FULL, dut4.cnt, dut4.sr, bus4.QSR);
        end
        bus4.S = MODE_LOAD; bus4.P = 4'h9;
        tick();
        bus4.S = MODE_HOLD;
        checks++;
        if (bus4.FULL !== 1'b0 || dut4.cnt !== 3'd0 || dut4.sr !== 4'h9) begin
            errors++;
            $display("FAIL sat_load_clear FULL=%b CNT=%0d SR=%h required 0 0 9", bus4.FULL, dut4.cnt, dut4.sr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus8.S = MODE_HOLD; bus8.DSR = 1'b0; bus8.DSL = 1'b0; bus8.P = '0; bus8.ST = 1'b0; bus8.OE_N = 1'b0;
        bus4.S = MODE_HOLD; bus4.DSR = 1'b0; bus4.DSL = 1'b0; bus4.P = '0; bus4.ST = 1'b0; bus4.OE_N = 1'b0;
        RD = 1'b0;
        test_reset();
        test_parallel();
        test_serial_right();
        test_shift_left();
        test_st_with_shift();
        test_last_bit_store();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzx_shift_store_reg.md
# lzx_shift_store_reg

Parametrised universal shift/storage register: a WIDTH-bit shift stage with hold, shift-right, shift-left and parallel-load modes, plus a separate WIDTH-bit storage stage that drives the outputs. It generalises the team's discrete D-flip-flop parts into a single configurable 74HC194/595-style block for serial-to-parallel and parallel-to-serial conversion in the gate library. Serial cascade outputs allow chaining instances, and a shift counter reports when a full word has been shifted in.

## Interface
- WIDTH, default 8: number of register bits; legal range 2..32.
- CNT_W, default $clog2(WIDTH+1): width of the shift counter; derived, not overridden.
- CLK  input  1  sole clock; all state updates on rising edge.
- RD  input  1  reset, asynchronous, active-low; clears every register.
- S  input  2  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- DSR  input  1  serial input, enters bit WIDTH-1 on shift right.
- DSL  input  1  serial input, enters bit 0 on shift left.
- P  input  WIDTH  parallel load data.
- ST  input  1  storage strobe; copies the shift stage into the storage stage.
- OE_N  input  1  output enable, active-low.
- Q  output  WIDTH  storage stage when OE_N=0, else all zeros.
- QSR  output  1  cascade out for shift right, equal to shift-stage bit 0 (ungated by OE_N).
- QSL  output  1  cascade out for shift left, equal to shift-stage bit WIDTH-1 (ungated by OE_N).
- FULL  output  1  high when the shift counter equals WIDTH.

## Operation
- Shift stage SR[WIDTH-1:0] per clock edge:
  - 00: hold.
  - 01: SR <= {DSR, SR[WIDTH-1:1]}.
  - 10: SR <= {SR[WIDTH-2:0], DSL}.
  - 11: SR <= P.
- Storage stage ST_R: when ST=1 it captures SR as it was before this edge (pre-update value), regardless of S. This gives one-cycle pipelining, equivalent to a 595 with tied clocks.
- Shift counter CNT:
  - Parallel load (11) sets CNT to 0.
  - Each shift (01 or 10) increments CNT, saturating at WIDTH.
  - Hold leaves CNT unchanged.
  - ST=1 clears CNT to 0, taking priority over an increment in the same cycle. If ST and a shift coincide, CNT becomes 0, not 1.
- FULL = (CNT == WIDTH); it is combinational from CNT.
- Q = OE_N ? '0 : ST_R. OE_N affects nothing but Q.
- Reset (RD=0), asynchronous and effective immediately, even mid-shift:
  - SR=0, ST_R=0, CNT=0.
  - Outputs become Q=0, QSR=0, QSL=0, FULL=0.
  - While RD=0, all clock edges are ignored.
- Release of RD is taken synchronously by the integrator. The first edge after release operates normally.

## Timing
- Shift and load results appear on QSR/QSL one edge after the command.
- Parallel data reaches Q two edges after load: load at edge n, ST at edge n+1, Q valid after edge n+1 when OE_N=0.
- Serial word assembly:
  - WIDTH shift edges bring FULL high after the WIDTH-th edge.
  - ST on the next edge presents the word on Q and drops FULL.
- ST asserted on the same edge as the WIDTH-th shift stores the word minus its last bit. The bench checks this as the defined behaviour.
- A saturated counter stays at WIDTH under further shifts. SR keeps shifting and data falls out via the QSR/QSL cascade.
- OE_N is combinational to Q, with no clock involvement.

## Structure
- Shared package lzx_gate_pkg holds the mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, so benches and future 74-series blocks share the encoding.
- One sub-module: lzx_univ_shift_core, containing the SR, the mode mux and the cascade outputs.
- The top level adds the storage stage, the counter and the output gating.

## Test plan
- Reset: drive RD=0 mid-shift with SR=8'hA5 → Q, QSR, QSL and FULL are 0 immediately. Edges during reset change nothing.
- Parallel path: WIDTH=8, S=11 with P=8'h3C, then ST=1 with OE_N=0 → Q=8'h3C after the second edge. OE_N=1 → Q=8'h00 while the internal value is retained.
- Serial right: from SR=0, shift right 8 edges with DSR sequence 1,0,1,1,0,0,1,0 → FULL=1 after edge 8. ST → Q=8'h4D, FULL=0.
- Shift left and cascade: load 8'h81, shift left once with DSL=0 → SR=8'h02. QSL is 1 before the edge and 0 after it.
- Simultaneous ST and shift: load 8'hF0, then ST=1 with S=01 and DSR=1 on the same edge → Q=8'hF0 (pre-shift), SR=8'hF8, CNT=0.
- Saturation and parameter: WIDTH=4, shift 6 times → FULL remains 1, CNT=4. Parallel load clears FULL.
